// File: rtl/midi_tx_engine.sv
// ============================================================================
// Module      : midi_tx_engine
// Description : MIDI serial transmitter. Complete messages are queued in a
//               small FIFO and sent one byte at a time as 8N1 frames
//               (start, 8 data bits LSB first, stop) at BAUD_DIV clk per bit.
//               The bytes of one message go out with no gap between frames.
// Options     : `define MIDI_RUNNING_STATUS_EN to omit a channel status byte
//               that repeats the last transmitted status (running status).
// Ports       : clk        - system clock, all logic on posedge
//               rst_i      - asynchronous active-high reset
//               msg_valid  - message offered
//               msg_ready  - FIFO can accept a message
//               msg_status - status byte
//               msg_data1  - first data byte
//               msg_data2  - second data byte
//               msg_len    - bytes to send (1..3, 0 = discard)
//               midi_tx    - serial MIDI line, idle high
//               busy       - FIFO non-empty or a message in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_tx_engine #(
    parameter int BAUD_DIV   = 3200,   // clk cycles per bit, must be >= 2
    parameter int FIFO_DEPTH = 4       // queued messages, power of 2, >= 2
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic [1:0] msg_len,
    output logic       midi_tx,
    output logic       busy
);

    localparam int c_baud_w = $clog2(BAUD_DIV);
    localparam int c_aw     = $clog2(FIFO_DEPTH);

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_baud_w-1:0] c_baud_zero = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Message FIFO: {status, data1, data2, len}
    // ------------------------------------------------------------------
    logic [25:0]   r_mem [FIFO_DEPTH];
    logic [c_aw:0] r_wptr;
    logic [c_aw:0] r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [25:0]   w_head;
    logic [7:0]    w_head_status;
    logic [1:0]    w_head_len;

    state_t r_state;
    state_t w_state_nxt;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign msg_ready = !w_full;

    // A zero-length message is handshaken but never stored.
    assign w_push = msg_valid && msg_ready && (msg_len != 2'd0);
    assign w_pop  = (r_state == S_IDLE) && !w_empty;

    assign w_head        = r_mem[r_rptr[c_aw-1:0]];
    assign w_head_status = w_head[25:18];
    assign w_head_len    = w_head[1:0];

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= {msg_status, msg_data1, msg_data2, msg_len};
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit datapath and FSM
    // ------------------------------------------------------------------
    logic [c_baud_w-1:0] r_baud,   w_baud_nxt;
    logic [2:0]          r_bit,    w_bit_nxt;
    logic [7:0]          r_shift,  w_shift_nxt;
    logic [1:0]          r_idx,    w_idx_nxt;
    logic                r_tx,     w_tx_nxt;
    logic [7:0]          r_status, w_status_nxt;
    logic [7:0]          r_d1,     w_d1_nxt;
    logic [7:0]          r_d2,     w_d2_nxt;
    logic [1:0]          r_len,    w_len_nxt;
    logic                w_skip;
    logic                w_more;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_rs, w_rs_nxt;

    // Channel status (0x80-0xEF) identical to the last one sent can be
    // omitted, provided the message carries at least one data byte.
    assign w_skip = (w_head_status >= 8'h80) && (w_head_status <= 8'hEF) &&
                    (w_head_status == r_rs) && (w_head_len >= 2'd2);
`else
    assign w_skip = 1'b0;
`endif

    // r_idx points at the next byte to load; bytes remain while it is below len.
    assign w_more = (r_idx < r_len);

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_tx_nxt     = r_tx;
        w_status_nxt = r_status;
        w_d1_nxt     = r_d1;
        w_d2_nxt     = r_d2;
        w_len_nxt    = r_len;
`ifdef MIDI_RUNNING_STATUS_EN
        w_rs_nxt     = r_rs;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    // Latch the whole message so later msg_* activity cannot alter it.
                    w_status_nxt = w_head[25:18];
                    w_d1_nxt     = w_head[17:10];
                    w_d2_nxt     = w_head[9:2];
                    w_len_nxt    = w_head[1:0];
                    w_idx_nxt    = w_skip ? 2'd1 : 2'd0;
                    w_state_nxt  = S_LOAD;
                end
            end

            S_LOAD: begin
                case (r_idx)
                    2'd0:    w_shift_nxt = r_status;
                    2'd1:    w_shift_nxt = r_d1;
                    default: w_shift_nxt = r_d2;
                endcase
`ifdef MIDI_RUNNING_STATUS_EN
                if (r_idx == 2'd0) begin
                    if ((r_status >= 8'h80) && (r_status <= 8'hEF)) begin
                        w_rs_nxt = r_status;
                    end else if ((r_status >= 8'hF0) && (r_status <= 8'hF7)) begin
                        w_rs_nxt = 8'h00;
                    end
                end
`endif
                w_idx_nxt   = r_idx + 2'd1;
                w_baud_nxt  = c_baud_last;
                w_tx_nxt    = 1'b0;
                w_state_nxt = S_START;
            end

            S_START: begin
                if (r_baud == c_baud_zero) begin
                    w_baud_nxt  = c_baud_last;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud - c_baud_one;
                end
            end

            S_DATA: begin
                if (r_baud == c_baud_zero) begin
                    w_baud_nxt = c_baud_last;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - c_baud_one;
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                // When another byte of this message follows, the LOAD cycle
                // is the last cycle of the stop bit, so leave one count early
                // and the frames abut with no gap.
                if (w_more && (r_baud == c_baud_one)) begin
                    w_state_nxt = S_LOAD;
                end else if (r_baud == c_baud_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud - c_baud_one;
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_status <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_len    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_tx     <= w_tx_nxt;
            r_status <= w_status_nxt;
            r_d1     <= w_d1_nxt;
            r_d2     <= w_d2_nxt;
            r_len    <= w_len_nxt;
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rs <= '0;
        end else begin
            r_rs <= w_rs_nxt;
        end
    end
`endif

    assign midi_tx = r_tx;
    assign busy    = !w_empty || (r_state != S_IDLE);

endmodule

`default_nettype wire
